// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction fetch bus: imem request/response, redirect/stall, IF/ID head
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - in-order instruction fetch with a small fetch buffer and redirect discard
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_fetch_unit_if.master     bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pc    [BUF_DEPTH];
  logic [31:0]   r_instr [BUF_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_nfilled;
  logic [7:0]    r_discard;

  logic          w_free;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_dropping;
  logic          w_fill;
  logic          w_drop;
  logic          w_if_valid;
  logic          w_deq;
  logic [PW-1:0] w_fill_idx;
  logic [CW-1:0] w_outstanding;
  logic [CW-1:0] w_remaining;

  // Filled entries are always a contiguous run starting at the head, so a count suffices.
  assign w_free        = r_count < CW'(BUF_DEPTH);
  assign w_req_valid   = w_free && !rst && !bus.redirect_valid;
  assign w_accept      = w_req_valid && bus.imem_req_ready;
  assign w_dropping    = r_discard != 8'd0;
  assign w_outstanding = r_count - r_nfilled;
  assign w_fill        = bus.imem_resp_valid && !rst && !w_dropping && (w_outstanding != '0);
  assign w_drop        = bus.imem_resp_valid && !rst && w_dropping;
  assign w_if_valid    = !rst && (r_nfilled != '0);
  assign w_deq         = w_if_valid && !bus.stall && !bus.redirect_valid;
  assign w_fill_idx    = r_head + r_nfilled[PW-1:0];
  assign w_remaining   = w_outstanding - CW'(w_fill);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_nfilled  <= '0;
      r_discard  <= 8'd0;
    end else if (bus.redirect_valid) begin
      // Responses still owed for older redirects stay in the discard count.
      r_fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_nfilled  <= '0;
      r_discard  <= r_discard - 8'(w_drop) + 8'(w_remaining);
    end else begin
      if (w_accept) begin
        r_tail     <= r_tail + 1'b1;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      r_count   <= r_count + CW'(w_accept) - CW'(w_deq);
      r_nfilled <= r_nfilled + CW'(w_fill) - CW'(w_deq);
      if (w_drop) begin
        r_discard <= r_discard - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pc[r_tail] <= r_fetch_pc;
    end
    if (w_fill) begin
      r_instr[w_fill_idx] <= bus.imem_resp_data;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.if_valid       = w_if_valid;
  assign bus.if_pc          = w_if_valid ? r_pc[r_head]    : 32'h0;
  assign bus.if_instr       = w_if_valid ? r_instr[r_head] : 32'h0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with an in-order memory model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        sb[$];
  logic [31:0] mq[$];
  int          cons_cyc[$];
  logic        resp_en  = 1'b0;
  logic        spurious = 1'b0;
  logic        mem_presenting = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept_n(input int n);
    bus.imem_req_ready = 1'b1;
    step(n);
    bus.imem_req_ready = 1'b0;
  endtask

  // Memory: records accepted addresses, returns them in order one cycle later when enabled.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (mem_presenting && mq.size() > 0) void'(mq.pop_front());
      if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) mq.push_back(bus.imem_req_addr);
    end
  end

  always @(posedge clk) begin
    #2;
    if (mq.size() > 0 && resp_en) begin
      mem_presenting      = 1'b1;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mq[0]);
    end else if (spurious) begin
      mem_presenting      = 1'b0;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hBAD0_BAD0;
    end else begin
      mem_presenting      = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
  end

  // Monitor: every consumed head is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst === 1'b0) begin
      if (bus.if_valid === 1'b1 && !bus.stall && !bus.redirect_valid) begin
        cons_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr actual pc=%h required none", bus.if_pc);
        end else begin
          e = sb.pop_front();
          chk("if_pc", bus.if_pc, e.pc);
          chk("if_instr", bus.if_instr, e.instr);
        end
      end else if (bus.if_valid !== 1'b1) begin
        chk("idle_if_pc", bus.if_pc, 32'h0);
        chk("idle_if_instr", bus.if_instr, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst                 = 1'b1;
    resp_en             = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.stall           = 1'b0;

    step(2);
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_addr", bus.imem_req_addr, 32'h0);
    chk("reset_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("reset_if_valid", 32'(bus.if_valid), 32'd0);
    @(posedge clk); #1;

    // Streaming with 1-cycle responses
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    accept_n(6);
    step(8);
    if (cons_cyc.size() >= 3) begin
      chk("consec_1", 32'(cons_cyc[1] - cons_cyc[0]), 32'd1);
      chk("consec_2", 32'(cons_cyc[2] - cons_cyc[1]), 32'd1);
    end else begin
      checks++;
      failures++;
      $display("FAIL consec actual=%0d consumed required=3", cons_cyc.size());
    end

    // Stall with a full buffer
    expect_pc(32'h18); expect_pc(32'h1C); expect_pc(32'h20); expect_pc(32'h24);
    bus.stall          = 1'b1;
    bus.imem_req_ready = 1'b1;
    step(5);
    repeat (3) begin
      @(negedge clk);
      chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("stall_if_valid", 32'(bus.if_valid), 32'd1);
      chk("stall_if_pc", bus.if_pc, 32'h18);
      chk("stall_if_instr", bus.if_instr, mem_word(32'h18));
    end
    @(posedge clk); #1;
    bus.stall          = 1'b0;
    bus.imem_req_ready = 1'b0;
    step(8);

    // Redirect with two unfilled requests outstanding
    resp_en = 1'b0;
    accept_n(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    @(negedge clk);
    chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    resp_en            = 1'b1;
    @(negedge clk);
    chk("redir_addr", bus.imem_req_addr, 32'h100);
    @(posedge clk); #1;
    expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
    accept_n(3);
    step(8);

    // Redirect in the same cycle a response fills an entry
    resp_en = 1'b0;
    accept_n(2);
    resp_en            = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    step(1);
    bus.redirect_valid = 1'b0;
    expect_pc(32'h200); expect_pc(32'h204);
    accept_n(2);
    step(8);

    // Address wrap
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    step(1);
    bus.redirect_valid = 1'b0;
    expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    bus.imem_req_ready = 1'b1;
    step(2);
    @(negedge clk);
    chk("wrap_addr", bus.imem_req_addr, 32'h0);
    @(posedge clk); #1;
    bus.imem_req_ready = 1'b0;
    step(8);

    // Spurious response while idle, then ready held low
    spurious = 1'b1;
    step(1);
    spurious = 1'b0;
    step(2);
    repeat (5) begin
      @(negedge clk);
      chk("hold_addr", bus.imem_req_addr, 32'h4);
      chk("hold_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("hold_if_valid", 32'(bus.if_valid), 32'd0);
    end
    @(posedge clk); #1;
    expect_pc(32'h4);
    accept_n(1);
    step(8);

    // Reset with requests outstanding
    resp_en = 1'b0;
    accept_n(2);
    rst = 1'b1;
    step(2);
    rst     = 1'b0;
    resp_en = 1'b1;
    expect_pc(32'h0);
    accept_n(1);
    step(8);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, fetch-buffer entries (power of two, 2..4).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request present.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_req_addr  output  32  fetch address, bits[1:0] always 0.
REQ-008 SHALL have port imem_resp_valid  input  1  instruction returned this cycle.
REQ-009 SHALL have port imem_resp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump/trap redirect.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port stall  input  1  decode stage not accepting (hazard stall).
REQ-013 SHALL have port if_valid  output  1  head instruction valid toward IF/ID.
REQ-014 SHALL have port if_pc  output  32  PC of head instruction.
REQ-015 SHALL have port if_instr  output  32  head instruction word.

Function
REQ-016 SHALL hold a fetch_pc register; imem_req_addr SHALL equal fetch_pc.
REQ-017 SHALL be a "request accepted" event exactly when imem_req_valid && imem_req_ready in one cycle; imem_req_valid MAY drop without acceptance.
REQ-018 SHALL assert imem_req_valid only when a buffer entry is free, rst is low and redirect_valid is low.
REQ-019 SHALL on request accepted allocate the tail entry {pc=fetch_pc, filled=0} and set fetch_pc <= fetch_pc+4, wrapping modulo 2^32.
REQ-020 SHALL treat responses as strictly in order; each non-discarded response fills the oldest unfilled entry with imem_resp_data.
REQ-021 SHALL drive if_valid = head entry allocated and filled; if_pc/if_instr = head fields; 32'h0 when if_valid low.
REQ-022 SHALL dequeue the head when if_valid && !stall; with stall high, head and outputs SHALL hold unchanged.
REQ-023 SHALL permit allocate, fill and dequeue in the same cycle; a full buffer SHALL accept a request in the cycle its head dequeues only if a free entry exists before that edge (no same-cycle bypass of full).
REQ-024 SHALL on redirect_valid: set fetch_pc <= {redirect_pc[31:2],2'b00}; clear all entries; set discard_cnt <= number of outstanding unfilled entries not filled in that same cycle.
REQ-025 SHALL drop (not store) each response arriving while discard_cnt > 0, decrementing discard_cnt; new requests MAY issue meanwhile and their responses are kept after discard_cnt reaches 0.
REQ-026 SHALL give redirect priority over stall and dequeue; a head presented in the redirect cycle is not consumed.
REQ-027 SHALL ignore imem_resp_valid with no outstanding entry and no discard pending (no state change).
REQ-028 SHALL have a minimum latency of 1 cycle from request acceptance to earliest if_valid (response the cycle after acceptance → if_valid the following cycle).

Reset
REQ-029 SHALL on rst high at a clock edge: fetch_pc <= RESET_PC, buffer empty, discard_cnt <= 0.
REQ-030 SHALL hold imem_req_valid=0 and if_valid=0 while rst is high; responses during reset SHALL be ignored.
REQ-031 SHALL on reset mid-operation abandon all outstanding requests without discard tracking (memory is reset with the core).

Verification
REQ-032 SHALL cover: reset release, ready=1, 1-cycle response → if_pc 0x0,0x4,0x8 on consecutive cycles, instructions in order.
REQ-033 SHALL cover: stall held 3 cycles with buffer full → imem_req_valid=0, if_pc/if_instr constant, no loss after release.
REQ-034 SHALL cover: redirect to 0x103 with 2 requests outstanding → next two responses dropped, next if_pc=0x100.
REQ-035 SHALL cover: redirect in same cycle as a response fills an entry → discard_cnt counts only the remaining outstanding entry.
REQ-036 SHALL cover: fetch_pc 0xFFFF_FFFC accepted → next imem_req_addr 0x0000_0000.
REQ-037 SHALL cover: imem_req_ready low 5 cycles → fetch_pc and buffer unchanged, first accepted address equals previous fetch_pc.
